// File: rtl/lsu_mem_responder.sv
// Single-outstanding memory responder for LSU load/store traffic: byte-lane
// masked writes and right-aligned reads, committed after a fixed latency.

module lsu_mem_lane (
  input  logic       wr_en,
  input  logic [7:0] old_byte,
  input  logic [7:0] new_byte,
  output logic [7:0] merged
);
  assign merged = wr_en ? new_byte : old_byte;
endmodule

module lsu_mem_responder #(
  parameter int          DEPTH   = 1024,
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int          LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_mask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);
  localparam int IW        = $clog2(DEPTH);
  localparam int NUM_LANES = 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        write;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  mask;
  } req_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic accept, commit;
  req_t req_in, req_q, req_cur;

  logic [63:0] mem [DEPTH];

  logic [63:0]                  rel;
  logic [2:0]                   off;
  logic [IW-1:0]                idx;
  logic [3:0]                   size;
  logic                         err;
  logic [NUM_LANES-1:0]         lanes;
  logic [NUM_LANES-1:0][7:0]    wsh, old_word, new_word, bmask;
  logic [63:0]                  rd_word;

  assign req_in    = {req_write, req_addr, req_wdata, req_mask};
  // The commit edge of a LATENCY==1 access is the accept edge itself.
  assign req_cur   = (state == IDLE) ? req_in : req_q;
  assign req_ready = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept    = req_valid && (state == IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      IDLE: if (req_valid) begin
        cnt_nxt = 4'(LATENCY - 1);
        if (LATENCY == 1) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end
      end
      RESP: if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // BASE is word aligned, so the low bits of the offset equal addr[2:0].
  always_comb begin
    rel   = req_cur.addr - BASE;
    off   = rel[2:0];
    idx   = rel[IW+2:3];
    case (req_cur.mask)
      8'h01:   size = 4'd1;
      8'h03:   size = 4'd2;
      8'h0F:   size = 4'd4;
      8'hFF:   size = 4'd8;
      default: size = 4'd0;
    endcase
    err   = (size == 4'd0) ||
            (({1'b0, off} & (size - 4'd1)) != 4'd0) ||
            (req_cur.addr < BASE) ||
            (rel[63:3] >= 61'(DEPTH));
    lanes    = req_cur.mask << off;
    wsh      = req_cur.wdata << {off, 3'b000};
    old_word = mem[idx];
    rd_word  = (old_word >> {off, 3'b000}) & bmask;
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    lsu_mem_lane u_lane (
      .wr_en    (lanes[k]),
      .old_byte (old_word[k]),
      .new_byte (wsh[k]),
      .merged   (new_word[k])
    );
    assign bmask[k] = {8{req_cur.mask[k]}};
  end

  // RAM has no reset; a commit can only land while reset is released.
  always_ff @(posedge clock) begin
    if (commit && reset && !err && req_cur.write) mem[idx] <= new_word;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_q      <= '0;
      resp_rdata <= 64'd0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) req_q <= req_in;
      if (commit) begin
        resp_err   <= err;
        resp_rdata <= (err || req_cur.write) ? 64'd0 : rd_word;
      end
    end
  end
endmodule
